// File: rtl/security_rx.sv
// Receive-side decryptor: undoes the per-word rotation/XOR, restores the
// frame's word order with a stack, and hands plaintext out through a FIFO.

module security_rx_dec #(
  parameter int               W   = 32,
  parameter logic [W-1:0]     KEY = 32'hA5C35A3C
) (
  input  logic [W-1:0] c,
  input  logic [4:0]   k,
  output logic [W-1:0] p
);
  logic [5:0] lsh;

  // k=0 gives a left shift of W, which yields zero, so no special case is needed
  assign lsh = 6'(W) - {1'b0, k};
  assign p   = ((c >> k) | (c << lsh)) ^ KEY;
endmodule

module security_rx #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 8,
  parameter logic [DATA_WIDTH-1:0] KEY        = 32'hA5C35A3C
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  busy,
  output logic                  err
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [AW:0] ONE  = 1;

  typedef enum logic {COLLECT, UNSTACK} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   stk  [DEPTH];
  logic [DATA_WIDTH-1:0]   fmem [DEPTH];
  logic [AW:0]             sp;
  logic [AW:0]             cnt;
  logic [AW-1:0]           wp, rp, top_idx;
  logic [4:0]              k;
  logic [DATA_WIDTH-1:0]   plain, top;
  logic                    stk_full, stk_we, push, pop;

  security_rx_dec #(.W(DATA_WIDTH), .KEY(KEY)) u_dec (
    .c (data_in),
    .k (k),
    .p (plain)
  );

  assign stk_full   = (sp == FULL);
  assign stk_we     = (state == COLLECT) && wr && !stk_full;
  assign top_idx    = AW'(sp - ONE);
  assign top        = stk[top_idx];
  // push stalls on the registered full flag; a same-cycle rd does not release it
  assign push       = (state == UNSTACK) && (sp != '0) && !fifo_full;
  assign pop        = rd && !fifo_empty;
  assign fifo_full  = (cnt == FULL);
  assign fifo_empty = (cnt == '0);
  assign busy       = (state == UNSTACK);

  always_ff @(posedge clk) begin
    if (stk_we) stk[sp[AW-1:0]] <= plain;
  end

  always_ff @(posedge clk) begin
    if (push) fmem[wp] <= top;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      sp    <= '0;
      k     <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (wr) begin
            if (!stk_full) begin
              sp <= sp + ONE;
              k  <= k + 5'd1;
            end else begin
              err <= 1'b1;
            end
            if (last) state <= UNSTACK;
          end
        end
        UNSTACK: begin
          if (wr) err <= 1'b1;
          if (sp == '0) begin
            state <= COLLECT;
            k     <= '0;
          end else if (!fifo_full) begin
            sp <= sp - ONE;
            if (sp == ONE) begin
              state <= COLLECT;
              k     <= '0;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pop;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp       <= rp + 1'b1;
        data_out <= fmem[rp];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_security_rx.sv
// Scoreboard bench for security_rx: a transmitter model encrypts random
// frames, expected plaintexts are queued and matched as words emerge.

module tb_security_rx;
  localparam int          DEPTH = 8;
  localparam logic [31:0] KEY   = 32'hA5C35A3C;

  logic        clk = 1'b0;
  logic        rst, wr, last, rd;
  logic [31:0] data_in, data_out;
  logic        out_valid, fifo_full, fifo_empty, busy, err;
  logic        wr64, last64, rd64;
  logic [31:0] din64, dout64;
  logic        ov64, ff64, fe64, busy64, err64;

  int          checks = 0, errors = 0, nout = 0;
  logic [31:0] q[$], q64[$];
  logic [31:0] mon_e, mon_last;

  always #5 clk = ~clk;

  security_rx #(.DATA_WIDTH(32), .DEPTH(DEPTH), .KEY(KEY)) dut (
    .clk(clk), .rst(rst), .wr(wr), .last(last), .data_in(data_in), .rd(rd),
    .data_out(data_out), .out_valid(out_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .busy(busy), .err(err)
  );

  security_rx #(.DATA_WIDTH(32), .DEPTH(64), .KEY(KEY)) dut64 (
    .clk(clk), .rst(rst), .wr(wr64), .last(last64), .data_in(din64), .rd(rd64),
    .data_out(dout64), .out_valid(ov64), .fifo_full(ff64),
    .fifo_empty(fe64), .busy(busy64), .err(err64)
  );

  // transmitter side: c = ROL(p ^ KEY, k mod 32)
  function automatic logic [31:0] enc(input logic [31:0] p, input int k);
    logic [31:0] x;
    int r;
    x = p ^ KEY;
    r = k % 32;
    return (r == 0) ? x : ((x << r) | (x >> (32 - r)));
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got %h with no word expected", data_out);
      end else begin
        mon_e = q.pop_front();
        mon_last = mon_e;
        if (data_out !== mon_e) begin
          errors++;
          $display("FAIL out_word got %h want %h", data_out, mon_e);
        end
      end
      nout++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; wr = 0; last = 0; rd = 0; wr64 = 0; last64 = 0; rd64 = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic write_words(input logic [31:0] cs[$], input bit with_last);
    foreach (cs[j]) begin
      @(negedge clk);
      wr = 1; data_in = cs[j]; last = with_last && (j == cs.size() - 1);
    end
    @(negedge clk);
    wr = 0; last = 0;
  endtask

  task automatic send(input int n);
    logic [31:0] pa[$], cs[$];
    for (int j = 0; j < n; j++) begin
      pa.push_back($urandom);
      cs.push_back(enc(pa[j], j));
    end
    for (int j = ((n < DEPTH) ? n : DEPTH) - 1; j >= 0; j--) q.push_back(pa[j]);
    write_words(cs, 1'b1);
  endtask

  task automatic junk(input int n, input bit with_last);
    logic [31:0] cs[$];
    for (int j = 0; j < n; j++) cs.push_back($urandom);
    write_words(cs, with_last);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy !== 1'b0 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_timeout busy got %b want 0", busy); end
  endtask

  task automatic drain(input int n);
    int goal = nout + n;
    int cyc = 0;
    rd = 1;
    while (nout < goal && cyc < 200) begin @(negedge clk); cyc++; end
    rd = 0;
    checks++;
    if (nout != goal) begin errors++; $display("FAIL drain_count got %0d want %0d", nout, goal); end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data_out got %h want 0", data_out); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_fifo_empty got %b want 1", fifo_empty); end
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_fifo_full got %b want 0", fifo_full); end
  endtask

  task automatic test_basic();
    logic [31:0] cs[$];
    cs.push_back(32'hC6AB3B53);
    cs.push_back(32'h4B7666A5);
    q.push_back(32'h0078696E);
    q.push_back(32'h6368616F);
    write_words(cs, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_idle();
    checks++;
    if (fifo_empty !== 1'b0) begin errors++; $display("FAIL basic_not_empty got %b want 0", fifo_empty); end
    drain(2);
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_ov_pulse got %b want 0", out_valid); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", fifo_empty); end
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
    if (q.size() != 0) begin errors++; $display("FAIL basic_left got %0d want 0", q.size()); end
  endtask

  task automatic test_rot_wrap();
    logic [31:0] pa[$];
    logic [31:0] e;
    int got = 0, cyc = 0;
    for (int j = 0; j < 35; j++) pa.push_back($urandom);
    for (int j = 34; j >= 0; j--) q64.push_back(pa[j]);
    for (int j = 0; j < 35; j++) begin
      @(negedge clk);
      wr64 = 1; last64 = (j == 34); din64 = enc(pa[j], j);
    end
    @(negedge clk);
    wr64 = 0; last64 = 0; rd64 = 1;
    while (got < 35 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (ov64 === 1'b1) begin
        checks++;
        e = q64.pop_front();
        if (dout64 !== e) begin errors++; $display("FAIL rot64_word %0d got %h want %h", got, dout64, e); end
        got++;
      end
    end
    rd64 = 0;
    checks += 2;
    if (got != 35) begin errors++; $display("FAIL rot64_count got %0d want 35", got); end
    if (err64 !== 1'b0) begin errors++; $display("FAIL rot64_err got %b want 0", err64); end
    send(8);
    wait_idle();
    drain(8);
    checks += 2;
    if (err !== 1'b0) begin errors++; $display("FAIL rot8_err got %b want 0", err); end
    if (q.size() != 0) begin errors++; $display("FAIL rot8_left got %0d want 0", q.size()); end
  endtask

  task automatic test_empty_simul();
    int start;
    @(negedge clk);
    rd = 1;
    @(negedge clk);
    rd = 0;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_rd_ov got %b want 0", out_valid); end
    if (data_out !== mon_last) begin errors++; $display("FAIL empty_rd_hold got %h want %h", data_out, mon_last); end
    start = nout;
    rd = 1;
    send(8);
    wait_idle();
    checks += 2;
    if (nout - start != 7) begin errors++; $display("FAIL simul_mid_count got %0d want 7", nout - start); end
    if (fifo_empty !== 1'b0) begin errors++; $display("FAIL simul_mid_empty got %b want 0", fifo_empty); end
    @(negedge clk);
    rd = 0;
    checks += 3;
    if (nout - start != 8) begin errors++; $display("FAIL simul_end_count got %0d want 8", nout - start); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL simul_end_empty got %b want 1", fifo_empty); end
    if (q.size() != 0) begin errors++; $display("FAIL simul_left got %0d want 0", q.size()); end
  endtask

  task automatic test_stall();
    int start;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL stall_err_pre got %b want 0", err); end
    send(8);
    junk(3, 1'b0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL stall_drop_err got %b want 1", err); end
    wait_idle();
    checks++;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL stall_full got %b want 1", fifo_full); end
    start = nout;
    send(8);
    repeat (4) @(negedge clk);
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b want 1", busy); end
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL stall_full2 got %b want 1", fifo_full); end
    if (nout != start) begin errors++; $display("FAIL stall_no_out got %0d want %0d", nout, start); end
    drain(16);
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_done_busy got %b want 0", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL stall_done_empty got %b want 1", fifo_empty); end
    if (q.size() != 0) begin errors++; $display("FAIL stall_left got %0d want 0", q.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_pre got %b want 0", err); end
    send(9);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", err); end
    wait_idle();
    drain(8);
    repeat (3) @(negedge clk);
    checks += 2;
    if (err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", err); end
    if (q.size() != 0) begin errors++; $display("FAIL ovf_left got %0d want 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    int start;
    junk(3, 1'b0);
    do_reset();
    checks += 5;
    if (data_out !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h want 0", data_out); end
    if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b want 0", err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %b want 1", fifo_empty); end
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL mid_rst_full got %b want 0", fifo_full); end
    start = nout;
    send(2);
    wait_idle();
    drain(2);
    rd = 1;
    repeat (4) @(negedge clk);
    rd = 0;
    checks += 3;
    if (nout - start != 2) begin errors++; $display("FAIL mid_count got %0d want 2", nout - start); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", fifo_empty); end
    if (q.size() != 0) begin errors++; $display("FAIL mid_left got %0d want 0", q.size()); end
  endtask

  initial begin
    rst = 1; wr = 0; last = 0; rd = 0; data_in = '0;
    wr64 = 0; last64 = 0; rd64 = 0; din64 = '0;
    mon_last = '0;
    test_reset();
    test_basic();
    test_rot_wrap();
    test_empty_simul();
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/security_rx.md
Name: security_rx

Overview:
- Receive-side counterpart of the security block. Accepts a frame of encrypted 32-bit words that arrives in reversed word order with a per-word rotation, and decrypts each word.
- Restores the original word order through an internal stack.
- Delivers plaintext through an output FIFO with a read strobe.
- Sits between the link/cipher input and the plaintext consumer.

Parameters:
- DATA_WIDTH, 32, word width (only 32 is supported).
- DEPTH, 8, maximum words per frame; also the output FIFO depth. Must be a power of 2, at least 2.
- KEY, 32'hA5C35A3C, XOR key shared with the transmitter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr  in  1  cipher word strobe; data_in is valid when high.
- last  in  1  marks the final word of a frame; sampled only when wr=1.
- data_in  in  32  cipher word.
- rd  in  1  pop one plaintext word from the output FIFO.
- data_out  out  32  registered plaintext word.
- out_valid  out  1  one-cycle pulse; data_out updated this cycle.
- fifo_full  out  1  output FIFO holds DEPTH words.
- fifo_empty  out  1  output FIFO holds 0 words.
- busy  out  1  high while in UNSTACK.
- err  out  1  sticky drop flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at an edge): state=COLLECT, stack and FIFO emptied, arrival index k=0, data_out=0, out_valid=0, err=0, busy=0, fifo_empty=1, fifo_full=0. Reset mid-frame discards all buffered data.
- Cipher definition:
  - Transmitter sends c = ROL(p ^ KEY, k mod 32).
  - This block computes p = ROR(c, k mod 32) ^ KEY.
  - k is the 0-based arrival index within the frame.
  - Decryption is combinational on the write path; the result is stored in the same cycle.
- State COLLECT:
  - wr=1 with stack not full: push decrypted word, k<=k+1.
  - wr=1 with stack full: word dropped, err<=1, k unchanged.
  - wr=1 with last=1: word handled as above, then state<=UNSTACK at the next edge. This transition happens even if the word was dropped.
  - last=1 on a dropped word with an empty stack cannot occur because DEPTH is at least 2. Nonetheless, if the stack is empty when entering UNSTACK, return to COLLECT immediately.
- State UNSTACK (busy=1):
  - Each cycle with fifo_full=0 (registered value), pop the stack top and push it into the output FIFO. The pop stalls while full.
  - The cycle that moves the last stack entry transitions to COLLECT and sets k<=0.
  - wr=1 in UNSTACK: word dropped, err<=1.
- Order: stack pops the newest arrival first. The transmitter sent the frame reversed, so the FIFO receives the original order.
- Read:
  - rd=1 with fifo_empty=0: data_out<=head, out_valid<=1 at the next edge (1-cycle latency).
  - rd=1 with fifo_empty=1: ignored; data_out holds; out_valid=0.
- Simultaneous FIFO push (UNSTACK) and pop (rd) in one cycle: both occur; count unchanged. The push stalls only on the registered fifo_full, so a rd in the same cycle does not unstall it.
- fifo_full and fifo_empty are derived from a registered count and change the cycle after the push/pop.
- Wrap-around: FIFO pointers are log2(DEPTH) bits wide and wrap naturally; the count is log2(DEPTH)+1 bits. k wraps modulo 32 for rotation purposes.
- Latency: last accepted at edge T → busy=1 after T. The first FIFO push happens at T+1, so fifo_empty=0 after T+1. An n-word frame fully drains by T+n with no stalls.

Test Plan:
- Basic frame, KEY default:
  - Stimulus: wr 0xC6AB3B53 (last=0), then wr 0x4B7666A5 (last=1), wait for busy=0, then rd twice on consecutive cycles.
  - Response: data_out=0x0078696E then 0x6368616F, with out_valid pulses one cycle after each rd; fifo_empty=1 afterwards; err=0.
- Rotation wrap:
  - Stimulus: a 3-word frame with k continuing from a 32-word DEPTH=64 build. Separately, a DEPTH=8 frame of 8 words whose ciphers are generated with k=0..7.
  - Response: all 8 plaintexts read back in original order; err=0.
- Overflow:
  - Stimulus: 9 words, last on the 9th, DEPTH=8.
  - Response: 9th dropped, err=1 sticky, 8 words delivered in order.
- Stall:
  - Stimulus: two back-to-back 8-word frames with no rd.
  - Response: fifo_full=1 after the first frame; the second frame's writes arriving during UNSTACK are dropped and set err. Arrival after busy=0 is accepted. UNSTACK stalls until rd frees space, then resumes without loss.
- Empty read and simultaneous push/rd:
  - Stimulus: rd with fifo_empty=1; then rd asserted continuously during an UNSTACK.
  - Response: the empty read leaves data_out unchanged and out_valid=0. During UNSTACK the FIFO count never exceeds 1 and words emerge in order.
- Reset mid-frame:
  - Stimulus: assert rst after 3 words are collected, then send a fresh 2-word frame.
  - Response: all outputs at reset values; only the 2 new plaintexts are delivered; k restarts at 0.
